// File: rtl/proc_pkg.sv
// Shared processor definitions: CSR access modes and CSR funct3 encodings.
package proc_pkg;

    // Kind of side effect requested on the CSR file for the current access.
    typedef enum logic [1:0] {
        CSR_NONE       = 2'd0,
        CSR_READ_WRITE = 2'd1,
        CSR_SET        = 2'd2,
        CSR_CLR        = 2'd3
    } csr_mode_t;

    // funct3 encodings of the Zicsr instructions.
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // 000 and 100 are the only funct3 values without a CSR instruction.
    function automatic logic f3_is_csr(input logic [2:0] f3);
        return f3[1:0] != 2'b00;
    endfunction

    // Bit 2 selects the immediate (zimm) source instead of rs1.
    function automatic logic f3_is_imm(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/csr_ctrl.sv
// CSR instruction sequencer: reads the old CSR value, performs the
// (optional) write, waits for the CSR file's registered exception flag and
// returns either a writeback or an exception in a single DONE cycle.
//
// Handshake: a request is taken on a rising edge where req_valid_i and
// req_ready_o are both high and flush_i is low; req_ready_o is high only
// while idle, and the request fields need only be stable on that edge.
module csr_ctrl
    import proc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_funct3_i,
    input  logic [11:0] req_csr_addr_i,
    input  logic [31:0] req_rs1_val_i,
    input  logic [4:0]  req_rs1_idx_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,
    output logic [12:0] csr_addr_o,
    output csr_mode_t   csr_mode_o,
    output logic [31:0] csr_wdata_o,
    input  logic [31:0] csr_rdata_i,
    input  logic        csr_exc_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        exc_valid_o,
    output logic [31:0] exc_tval_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_WRITE    = 3'd2,
        S_WAIT_EXC = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t      state_q, state_d;

    logic [2:0]  funct3_q;
    logic [11:0] addr_q;
    logic [31:0] rs1_val_q;
    logic [4:0]  rs1_idx_q;
    logic [4:0]  rd_q;
    logic [31:0] old_q;
    logic        illegal_q;

    logic        accept;
    logic        write_intent;
    logic        ro_violation;
    csr_mode_t   wr_mode;
    logic [31:0] wr_data;

    // A flush in the same cycle as a valid request suppresses the accept.
    assign accept      = req_valid_i && (state_q == S_IDLE) && !flush_i;
    assign dbg_state_o = state_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; non-CSR funct3 values skip straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = f3_is_csr(req_funct3_i) ? S_READ : S_DONE;
                end
            end
            S_READ:     state_d = flush_i ? S_IDLE : S_WRITE;
            S_WRITE:    state_d = S_WAIT_EXC;
            S_WAIT_EXC: state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Decode the write side of the captured instruction. Set/clear with a
    // zero source have no write intent, so they never hit the read-only check.
    always_comb begin
        write_intent = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
        ro_violation = write_intent && (addr_q[11:10] == 2'b11);
        wr_data      = f3_is_imm(funct3_q) ? {27'd0, rs1_idx_q} : rs1_val_q;
        case (funct3_q[1:0])
            2'b01:   wr_mode = CSR_READ_WRITE;
            2'b10:   wr_mode = CSR_SET;
            2'b11:   wr_mode = CSR_CLR;
            default: wr_mode = CSR_NONE;
        endcase
        if (!write_intent || ro_violation) begin
            wr_mode = CSR_NONE;
        end
    end

    // Request capture, old-value latch and accumulation of the illegal flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            funct3_q  <= 3'd0;
            addr_q    <= 12'd0;
            rs1_val_q <= 32'd0;
            rs1_idx_q <= 5'd0;
            rd_q      <= 5'd0;
            old_q     <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                funct3_q  <= req_funct3_i;
                addr_q    <= req_csr_addr_i;
                rs1_val_q <= req_rs1_val_i;
                rs1_idx_q <= req_rs1_idx_i;
                rd_q      <= req_rd_i;
                old_q     <= 32'd0;
                illegal_q <= !f3_is_csr(req_funct3_i);
            end
            if (state_q == S_READ && !flush_i) begin
                old_q <= csr_rdata_i;
            end
            if (state_q == S_WRITE && ro_violation) begin
                illegal_q <= 1'b1;
            end
            if (state_q == S_WAIT_EXC && csr_exc_i) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Outputs decoded from the current state; everything idles at zero/NONE.
    always_comb begin
        req_ready_o = 1'b0;
        csr_addr_o  = 13'd0;
        csr_mode_o  = CSR_NONE;
        csr_wdata_o = 32'd0;
        wb_valid_o  = 1'b0;
        wb_rd_o     = 5'd0;
        wb_data_o   = 32'd0;
        exc_valid_o = 1'b0;
        exc_tval_o  = 32'd0;
        case (state_q)
            S_IDLE: req_ready_o = 1'b1;
            S_READ: csr_addr_o = {1'b0, addr_q};
            S_WRITE: begin
                csr_addr_o = {1'b0, addr_q};
                csr_mode_o = wr_mode;
                if (wr_mode != CSR_NONE) begin
                    csr_wdata_o = wr_data;
                end
            end
            S_DONE: begin
                if (illegal_q) begin
                    exc_valid_o = 1'b1;
                    exc_tval_o  = {20'd0, addr_q};
                end else if (rd_q != 5'd0) begin
                    wb_valid_o = 1'b1;
                    wb_rd_o    = rd_q;
                    wb_data_o  = old_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/csr_ctrl.md
CSR_CTRL -- requirements
Module: csr_ctrl

Interface
REQ-001 SHALL have ports clk_i, in, 1: clock; rst_n_i, in, 1: reset, asynchronous, active-low; clock clk_i.
REQ-002 SHALL have req_valid_i, in, 1 and req_ready_o, out, 1: CSR instruction handshake.
REQ-003 SHALL have req_funct3_i, in, 3: 001 CSRRW, 010 CSRRS, 011 CSRRC, 101 CSRRWI, 110 CSRRSI, 111 CSRRCI.
REQ-004 SHALL have req_csr_addr_i, in, 12; req_rs1_val_i, in, 32; req_rs1_idx_i, in, 5 (zimm for imm forms); req_rd_i, in, 5.
REQ-005 SHALL have flush_i, in, 1: pipeline kill.
REQ-006 SHALL have csr_addr_o, out, 13; csr_mode_o, out, 2 (csr_mode_t); csr_wdata_o, out, 32; csr_rdata_i, in, 32 (combinational read of csr_addr_o); csr_exc_i, in, 1 (registered, one cycle after access).
REQ-007 SHALL have wb_valid_o, out, 1; wb_rd_o, out, 5; wb_data_o, out, 32; exc_valid_o, out, 1; exc_tval_o, out, 32 (offending instruction CSR address, zero-extended).

Function
REQ-008 SHALL implement FSM IDLE -> READ -> WRITE -> WAIT_EXC -> DONE -> IDLE; req_ready_o=1 only in IDLE.
REQ-009 SHALL capture all req_* fields into registers on req_valid_i&&req_ready_o; inputs ignored otherwise.
REQ-010 READ: csr_addr_o = {1'b0, captured addr}, csr_mode_o=NONE, old value latched from csr_rdata_i at end of cycle.
REQ-011 WRITE: csr_wdata_o = rs1 value (reg forms) or zero-extended 5-bit zimm (imm forms); csr_mode_o = READ_WRITE for RW, SET for RS, CLR for RC.
REQ-012 RS/RC/RSI/RCI with source index/zimm == 0 SHALL drive csr_mode_o=NONE in WRITE (no side effect, no read-only check).
REQ-013 Write-intent to address with addr[11:10]==2'b11 SHALL skip WRITE access (mode NONE) and flag illegal.
REQ-014 funct3 000 or 100 SHALL flag illegal, go directly IDLE -> DONE, issue no CSR access.
REQ-015 WAIT_EXC: csr_mode_o=NONE; csr_exc_i sampled; 1 sets illegal flag.
REQ-016 DONE, one cycle: illegal -> exc_valid_o=1, wb_valid_o=0; else wb_valid_o=(rd!=0), wb_data_o=old value, wb_rd_o=rd.
REQ-017 Latency: accept at T, DONE at T+4 (T+1 for REQ-014); back-to-back accept at T+5.
REQ-018 csr_mode_o SHALL be NONE in IDLE, READ, WAIT_EXC, DONE.
REQ-019 flush_i in READ SHALL return to IDLE without write or response; flush_i in WRITE/WAIT_EXC/DONE ignored (access completes). flush_i with req_valid_i in IDLE: no accept.
REQ-020 wb_data_o/exc_tval_o SHALL be zero when their valid is low.

Reset
REQ-021 Reset SHALL force IDLE, req_ready_o=1, wb_valid_o=0, exc_valid_o=0, csr_mode_o=NONE, csr_addr_o=0, csr_wdata_o=0, captured registers 0.
REQ-022 Reset mid-operation SHALL abandon transaction; no further CSR access issued.

Structure
REQ-023 csr_mode_t (NONE, READ_WRITE, SET, CLR) and funct3 constants SHALL live in proc_pkg; FSM state enum local.
REQ-024 No sub-module; single module, target 150-250 lines.

Verification
REQ-025 CSRRW addr 0x340, rs1=0xDEADBEEF, rd=5, CSR holds 0x12 -> WRITE mode READ_WRITE wdata 0xDEADBEEF; T+4 wb_valid_o=1, rd=5, data=0x12.
REQ-026 CSRRSI addr 0x300, zimm=0 -> no write (mode NONE all cycles), wb returns old value; CSRRCI zimm=0x8 -> mode CLR, wdata 0x8.
REQ-027 CSRRW addr 0xF11 -> no write, exc_valid_o=1, exc_tval_o=0xF11, wb_valid_o=0; CSRRS addr 0xF11 rs1_idx=0 -> legal read.
REQ-028 CSRRW addr 0x7C0, csr_exc_i=1 in WAIT_EXC -> exc_valid_o=1 at T+4, tval 0x7C0.
REQ-029 funct3=100 -> exc_valid_o at T+1, no CSR access; flush_i in READ -> no write, no response, ready at next cycle.
REQ-030 rst_n_i low during WRITE -> outputs at reset values immediately; next request completes normally.
